// File: rtl/fu_issue_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : fu_issue_fifo_if
// Purpose  : Handshake bundle between the reservation station, the per-FU
//            issue FIFO and its functional unit.
// Revision : 1.0
// ============================================================================
interface fu_issue_fifo_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int IN_W   = 3
);
    logic                        squash;
    logic [IN_W-1:0]             in_valid;
    logic [IN_W*DATA_W-1:0]      in_data;
    logic                        fu_ready;
    logic                        out_valid;
    logic [DATA_W-1:0]           out_data;
    logic                        stall;
    logic [$clog2(DEPTH):0]      count;
    logic                        overflow;

    // Driver side: reservation station plus functional unit.
    modport master (
        output squash, in_valid, in_data, fu_ready,
        input  out_valid, out_data, stall, count, overflow
    );

    // The FIFO itself.
    modport slave (
        input  squash, in_valid, in_data, fu_ready,
        output out_valid, out_data, stall, count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/fu_issue_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fu_issue_fifo
// Purpose  : Per-FU issue buffer: up to IN_W compacted pushes per cycle, one
//            in-order pop per cycle. Optional macro FU_ISSUE_FIFO_FORWARD_EN
//            enables same-cycle bypass of the lowest lane into an empty FIFO.
// Revision : 1.0
// ============================================================================
module fu_issue_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int IN_W   = 3
) (
    input  wire               clock,
    input  wire               reset,
    fu_issue_fifo_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_IN_W  = CNT_W'(IN_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;

    logic [CNT_W-1:0]  w_free;
    logic [CNT_W-1:0]  w_n_acc;
    logic [PTR_W-1:0]  w_wr_idx;
    logic              w_pop;
    logic              w_fwd;
    logic              w_skip;
    logic              w_drop;
    logic              w_out_valid;
    logic [DATA_W-1:0] w_out_data;
`ifdef FU_ISSUE_FIFO_FORWARD_EN
    logic [DATA_W-1:0] w_fwd_data;
`endif

    always_comb begin
        // Space is judged on the registered count only; a same-cycle pop does not help.
        w_free      = c_DEPTH - count_q;
        w_out_valid = (count_q != '0);
        w_out_data  = mem_q[head_q];
        w_pop       = w_out_valid && bus.fu_ready;
        w_fwd       = 1'b0;
`ifdef FU_ISSUE_FIFO_FORWARD_EN
        w_fwd_data  = '0;
        w_fwd       = (count_q == '0) && bus.fu_ready && (|bus.in_valid) && !bus.squash;
`endif
        w_skip      = w_fwd;
        w_n_acc     = '0;
        w_wr_idx    = '0;
        w_drop      = 1'b0;
        mem_d       = mem_q;

        for (int i = 0; i < IN_W; i++) begin
            if (bus.in_valid[i] && !bus.squash) begin
                if (w_skip) begin
                    w_skip = 1'b0;
`ifdef FU_ISSUE_FIFO_FORWARD_EN
                    w_fwd_data = bus.in_data[i*DATA_W +: DATA_W];
`endif
                end else if (w_n_acc < w_free) begin
                    w_wr_idx        = tail_q + w_n_acc[PTR_W-1:0];
                    mem_d[w_wr_idx] = bus.in_data[i*DATA_W +: DATA_W];
                    w_n_acc         = w_n_acc + CNT_W'(1);
                end else begin
                    w_drop = 1'b1;
                end
            end
        end

`ifdef FU_ISSUE_FIFO_FORWARD_EN
        if (w_fwd) begin
            w_out_valid = 1'b1;
            w_out_data  = w_fwd_data;
        end
`endif

        head_d     = head_q + PTR_W'(w_pop);
        tail_d     = tail_q + w_n_acc[PTR_W-1:0];
        count_d    = count_q + w_n_acc - CNT_W'(w_pop);
        overflow_d = overflow_q | w_drop;

        // Squash empties the queue but leaves the sticky overflow flag alone.
        if (bus.squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.stall     = (w_free < c_IN_W);
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fu_issue_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_fu_issue_fifo
// Purpose  : Directed self-checking bench for fu_issue_fifo (default build).
// Revision : 1.0
// ============================================================================
module tb_fu_issue_fifo;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 8;
    localparam int IN_W   = 3;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    fu_issue_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IN_W(IN_W)) bus ();

    fu_issue_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IN_W(IN_W)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [2:0] v, input logic [63:0] a,
                             input logic [63:0] b, input logic [63:0] c);
        bus.in_valid = v;
        bus.in_data  = {c, b, a};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.squash = 1'b0;
        bus.fu_ready = 1'b0;
        set_lanes(3'b111, 64'h1, 64'h2, 64'h3);
        tick();
        tick();
        rst = 1'b0;
        set_lanes(3'b000, 64'h0, 64'h0, 64'h0);
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
    endtask

    task automatic test_compaction();
        set_lanes(3'b101, 64'hAAAA_0000_0000_000A, 64'hDEAD_BEEF_DEAD_BEEF, 64'hCCCC_0000_0000_000C);
        bus.fu_ready = 1'b0;
        tick();
        set_lanes(3'b000, 64'h0, 64'h0, 64'h0);
        checks++; if (bus.count !== 4'd2) begin errors++; $display("FAIL compact_count: got %0d expected 2", bus.count); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL compact_valid: got %b expected 1", bus.out_valid); end
        bus.fu_ready = 1'b1;
        checks++; if (bus.out_data !== 64'hAAAA_0000_0000_000A) begin errors++; $display("FAIL compact_first: got %h expected %h", bus.out_data, 64'hAAAA_0000_0000_000A); end
        tick();
        checks++; if (bus.out_data !== 64'hCCCC_0000_0000_000C) begin errors++; $display("FAIL compact_second: got %h expected %h", bus.out_data, 64'hCCCC_0000_0000_000C); end
        checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL compact_count_mid: got %0d expected 1", bus.count); end
        tick();
        bus.fu_ready = 1'b0;
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL compact_empty: got %0d expected 0", bus.count); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL compact_empty_valid: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_fill();
        bus.fu_ready = 1'b0;
        set_lanes(3'b111, 64'd1, 64'd2, 64'd3);
        tick();
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL fill_stall_3: got %b expected 0", bus.stall); end
        set_lanes(3'b111, 64'd4, 64'd5, 64'd6);
        tick();
        checks++; if (bus.count !== 4'd6) begin errors++; $display("FAIL fill_count_6: got %0d expected 6", bus.count); end
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL fill_stall_6: got %b expected 1", bus.stall); end
        set_lanes(3'b111, 64'd7, 64'd8, 64'd9);
        tick();
        set_lanes(3'b000, 64'h0, 64'h0, 64'h0);
        checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL fill_count_8: got %0d expected 8", bus.count); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow: got %b expected 1", bus.overflow); end
        bus.fu_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            checks++; if (bus.out_data !== 64'(k)) begin errors++; $display("FAIL fill_drain[%0d]: got %h expected %h", k, bus.out_data, 64'(k)); end
            tick();
        end
        bus.fu_ready = 1'b0;
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL fill_drained: got %0d expected 0", bus.count); end
    endtask

    task automatic test_full_pushpop();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.fu_ready = 1'b0;
        set_lanes(3'b111, 64'h11, 64'h12, 64'h13);
        tick();
        set_lanes(3'b111, 64'h14, 64'h15, 64'h16);
        tick();
        set_lanes(3'b011, 64'h17, 64'h18, 64'h0);
        tick();
        checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d expected 8", bus.count); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL full_no_overflow: got %b expected 0", bus.overflow); end
        set_lanes(3'b001, 64'h99, 64'h0, 64'h0);
        bus.fu_ready = 1'b1;
        tick();
        set_lanes(3'b000, 64'h0, 64'h0, 64'h0);
        checks++; if (bus.count !== 4'd7) begin errors++; $display("FAIL full_pushpop_count: got %0d expected 7", bus.count); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL full_pushpop_overflow: got %b expected 1", bus.overflow); end
        for (int k = 2; k <= 8; k++) begin
            checks++; if (bus.out_data !== 64'(16 + k)) begin errors++; $display("FAIL full_drain[%0d]: got %h expected %h", k, bus.out_data, 64'(16 + k)); end
            tick();
        end
        bus.fu_ready = 1'b0;
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL full_drained: got %0d expected 0", bus.count); end
    endtask

    task automatic test_squash();
        bus.fu_ready = 1'b0;
        set_lanes(3'b111, 64'h21, 64'h22, 64'h23);
        tick();
        set_lanes(3'b011, 64'h24, 64'h25, 64'h0);
        tick();
        checks++; if (bus.count !== 4'd5) begin errors++; $display("FAIL squash_pre_count: got %0d expected 5", bus.count); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL squash_pre_stall: got %b expected 0", bus.stall); end
        bus.squash = 1'b1;
        bus.fu_ready = 1'b1;
        set_lanes(3'b011, 64'h26, 64'h27, 64'h0);
        tick();
        bus.squash = 1'b0;
        bus.fu_ready = 1'b0;
        set_lanes(3'b000, 64'h0, 64'h0, 64'h0);
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL squash_count: got %0d expected 0", bus.count); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL squash_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL squash_overflow_kept: got %b expected 1", bus.overflow); end
        set_lanes(3'b001, 64'hD0D0_D0D0_D0D0_D0D0, 64'h0, 64'h0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL squash_no_bypass: got %b expected 0", bus.out_valid); end
        tick();
        set_lanes(3'b000, 64'h0, 64'h0, 64'h0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL squash_d_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.out_data !== 64'hD0D0_D0D0_D0D0_D0D0) begin errors++; $display("FAIL squash_d_data: got %h expected %h", bus.out_data, 64'hD0D0_D0D0_D0D0_D0D0); end
        bus.fu_ready = 1'b1;
        tick();
        bus.fu_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [63:0] v;
        logic [63:0] p;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            v = {32'hA5A5_0000 + 32'(k), ~(32'h0 + 32'(k))};
            p = {32'hA5A5_0000 + 32'(k - 1), ~(32'h0 + 32'(k - 1))};
            case (k % 3)
                0:       set_lanes(3'b001, v, 64'h0, 64'h0);
                1:       set_lanes(3'b010, 64'h0, v, 64'h0);
                default: set_lanes(3'b100, 64'h0, 64'h0, v);
            endcase
            bus.fu_ready = (k > 0);
            if (k > 0) begin
                checks++; if (bus.out_data !== p) begin errors++; $display("FAIL wrap_data[%0d]: got %h expected %h", k, bus.out_data, p); end
            end
            tick();
            checks++; if (bus.count > 4'd2) begin errors++; $display("FAIL wrap_count[%0d]: got %0d expected <=2", k, bus.count); end
        end
        set_lanes(3'b000, 64'h0, 64'h0, 64'h0);
        p = {32'hA5A5_0000 + 32'd19, ~32'd19};
        checks++; if (bus.out_data !== p) begin errors++; $display("FAIL wrap_last: got %h expected %h", bus.out_data, p); end
        bus.fu_ready = 1'b1;
        tick();
        bus.fu_ready = 1'b0;
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL wrap_empty: got %0d expected 0", bus.count); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.squash = 1'b0;
        bus.fu_ready = 1'b0;
        bus.in_valid = '0;
        bus.in_data = '0;
        test_reset();
        test_compaction();
        test_fill();
        test_full_pushpop();
        test_squash();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
